// File: rtl/cp0_exception_unit.sv
// CP0 registers, exception/ERET resolution, timer and interrupt-pending generation for the WB stage.
// Latency: flush/redirect combinational from WB inputs; register updates at the next edge. Backpressure: none.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  WB_ExceptType,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_ALUOut,
  input  logic        WB_IsDelaySlot,
  input  logic        WB_CP0Wr,
  input  logic [4:0]  WB_CP0Addr,
  input  logic [31:0] WB_OutB,
  input  logic [4:0]  CP0_RdAddr,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0_RdData,
  output logic        CP0_Flush,
  output logic [31:0] CP0_NPC,
  output logic        CP0_IntPending,
  output logic [31:0] CP0_Status
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [31:0]      badvaddr, count, compare, epc;
  logic [7:0]       im;
  logic             exl, ie, bd, ti;
  logic [5:0]       ip_hw;
  logic [1:0]       ip_sw;
  logic [4:0]       exc_code;
  logic [DIV_W-1:0] div_cnt;

  logic             exc_taken, eret, cp0_wr, count_tick, count_upd;
  logic [4:0]       exc_code_nxt;
  logic             bad_we;
  logic [31:0]      bad_nxt, count_nxt, epc_nxt, cause_rd;
  logic [DIV_W-1:0] div_nxt;
  logic [7:0]       cause_ip;

  // Eret (bit 2) is the lowest priority and is not an exception by itself.
  assign exc_taken = |{WB_ExceptType[8:3], WB_ExceptType[1:0]};
  assign eret      = WB_ExceptType[2];
  assign cp0_wr    = WB_CP0Wr & ~(|WB_ExceptType);

  assign CP0_Flush = ~rst & (exc_taken | eret);
  assign CP0_NPC   = exc_taken ? EXC_ENTRY : epc;
  assign epc_nxt   = WB_IsDelaySlot ? (WB_PC - 32'd4) : WB_PC;

  always_comb begin
    exc_code_nxt = exc_code;
    bad_we       = 1'b0;
    bad_nxt      = WB_ALUOut;
    if (WB_ExceptType[8]) begin
      exc_code_nxt = 5'h00;
    end else if (WB_ExceptType[7]) begin
      exc_code_nxt = 5'h04;
      bad_we       = 1'b1;
      bad_nxt      = WB_PC;
    end else if (WB_ExceptType[6]) begin
      exc_code_nxt = 5'h0A;
    end else if (WB_ExceptType[5]) begin
      exc_code_nxt = 5'h0C;
    end else if (WB_ExceptType[4]) begin
      exc_code_nxt = 5'h08;
    end else if (WB_ExceptType[3]) begin
      exc_code_nxt = 5'h09;
    end else if (WB_ExceptType[0]) begin
      exc_code_nxt = 5'h04;
      bad_we       = 1'b1;
    end else if (WB_ExceptType[1]) begin
      exc_code_nxt = 5'h05;
      bad_we       = 1'b1;
    end
  end

  assign count_tick = (div_cnt == DIV_LAST);

  always_comb begin
    count_nxt = count;
    div_nxt   = count_tick ? '0 : div_cnt + 1'b1;
    count_upd = count_tick;
    if (count_tick) count_nxt = count + 32'd1;
    // A software Count write restarts the divider phase as well.
    if (cp0_wr && WB_CP0Addr == ADDR_COUNT) begin
      count_nxt = WB_OutB;
      div_nxt   = '0;
      count_upd = 1'b1;
    end
  end

  assign cause_ip   = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign cause_rd   = {bd, ti, 14'b0, cause_ip, 1'b0, exc_code, 2'b0};
  assign CP0_Status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign CP0_IntPending = ie & ~exl & (|(cause_ip & im));

  always_comb begin
    CP0_RdData = 32'h0;
    case (CP0_RdAddr)
      ADDR_BADVADDR: CP0_RdData = badvaddr;
      ADDR_COUNT:    CP0_RdData = count;
      ADDR_COMPARE:  CP0_RdData = compare;
      ADDR_STATUS:   CP0_RdData = CP0_Status;
      ADDR_CAUSE:    CP0_RdData = cause_rd;
      ADDR_EPC:      CP0_RdData = epc;
      default:       CP0_RdData = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exc_code <= '0;
      div_cnt  <= '0;
    end else begin
      ip_hw   <= HWInt;
      count   <= count_nxt;
      div_cnt <= div_nxt;
      if (cp0_wr && WB_CP0Addr == ADDR_COMPARE) ti <= 1'b0;
      else if (count_upd && count_nxt == compare) ti <= 1'b1;
      if (cp0_wr) begin
        case (WB_CP0Addr)
          ADDR_COMPARE: compare <= WB_OutB;
          ADDR_STATUS: begin
            im  <= WB_OutB[15:8];
            exl <= WB_OutB[1];
            ie  <= WB_OutB[0];
          end
          ADDR_CAUSE:   ip_sw <= WB_OutB[9:8];
          ADDR_EPC:     epc <= WB_OutB;
          default: ;
        endcase
      end
      // Nested exceptions keep the original EPC/BD so the first handler can still return.
      if (exc_taken) begin
        exc_code <= exc_code_nxt;
        exl      <= 1'b1;
        if (!exl) begin
          epc <= epc_nxt;
          bd  <= WB_IsDelaySlot;
        end
        if (bad_we) badvaddr <= bad_nxt;
      end else if (eret) begin
        exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Randomized and directed bench for cp0_exception_unit against a field-level reference model.
module tb_cp0_exception_unit;

  localparam logic [31:0] ENTRY = 32'hBFC0_0380;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  WB_ExceptType = '0;
  logic [31:0] WB_PC = '0, WB_ALUOut = '0, WB_OutB = '0;
  logic        WB_IsDelaySlot = 1'b0, WB_CP0Wr = 1'b0;
  logic [4:0]  WB_CP0Addr = '0, CP0_RdAddr = '0;
  logic [5:0]  HWInt = '0;
  logic [31:0] CP0_RdData, CP0_NPC, CP0_Status;
  logic        CP0_Flush, CP0_IntPending;

  int total = 0;
  int bad = 0;
  logic next_rst = 1'b0;
  logic [5:0] cur_hw = '0;

  // reference model state
  logic [31:0] m_bad, m_count, m_cmp, m_epc, m_status;
  logic        m_bd, m_ti;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  int          m_cyc;

  // exception priority table: ExceptType bit, ExcCode, BadVAddr source (0 none, 1 PC, 2 ALUOut)
  int pri_bit[8]  = '{8, 7, 6, 5, 4, 3, 0, 1};
  int pri_code[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
  int pri_bsrc[8] = '{0, 1, 0, 0, 0, 0, 2, 2};

  cp0_exception_unit #(.EXC_ENTRY(ENTRY), .COUNT_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .WB_ExceptType(WB_ExceptType), .WB_PC(WB_PC), .WB_ALUOut(WB_ALUOut),
    .WB_IsDelaySlot(WB_IsDelaySlot), .WB_CP0Wr(WB_CP0Wr), .WB_CP0Addr(WB_CP0Addr),
    .WB_OutB(WB_OutB), .CP0_RdAddr(CP0_RdAddr), .HWInt(HWInt),
    .CP0_RdData(CP0_RdData), .CP0_Flush(CP0_Flush), .CP0_NPC(CP0_NPC),
    .CP0_IntPending(CP0_IntPending), .CP0_Status(CP0_Status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_hw | {m_ti, 5'b0}) << 10)
         | (32'(m_sw) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intpend();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  task automatic model_step();
    int hit;
    logic upd;
    logic old_exl;
    if (rst) begin
      m_bad = 0; m_count = 0; m_cmp = 0; m_epc = 0; m_status = 32'h0040_0000;
      m_bd = 0; m_ti = 0; m_hw = 0; m_sw = 0; m_code = 0; m_cyc = 0;
      return;
    end
    old_exl = m_status[1];
    m_cyc++;
    upd = 1'b0;
    if (m_cyc % DIV == 0) begin
      m_count = m_count + 1;
      upd = 1'b1;
    end
    if (WB_CP0Wr && WB_ExceptType == 0) begin
      case (WB_CP0Addr)
        5'd9:  begin m_count = WB_OutB; m_cyc = 0; upd = 1'b1; end
        5'd11: m_cmp = WB_OutB;
        5'd12: m_status = (m_status & ~32'h0000_FF03) | (WB_OutB & 32'h0000_FF03);
        5'd13: m_sw = WB_OutB[9:8];
        5'd14: m_epc = WB_OutB;
        default: ;
      endcase
    end
    if (WB_CP0Wr && WB_ExceptType == 0 && WB_CP0Addr == 5'd11) m_ti = 1'b0;
    else if (upd && m_count == m_cmp) m_ti = 1'b1;
    hit = -1;
    for (int i = 0; i < 8; i++)
      if (hit < 0 && WB_ExceptType[pri_bit[i]]) hit = i;
    if (hit >= 0) begin
      m_code = 5'(pri_code[hit]);
      if (!old_exl) begin
        m_epc = WB_IsDelaySlot ? WB_PC - 4 : WB_PC;
        m_bd  = WB_IsDelaySlot;
      end
      if (pri_bsrc[hit] == 1) m_bad = WB_PC;
      if (pri_bsrc[hit] == 2) m_bad = WB_ALUOut;
      m_status = m_status | 32'h2;
    end else if (WB_ExceptType[2]) begin
      m_status = m_status & ~32'h2;
    end
    m_hw = HWInt;
  endtask

  task automatic set_in(input logic [8:0] ex, input logic [31:0] pc, input logic [31:0] alu,
                        input logic ds, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra);
    logic e_flush;
    @(negedge clk);
    rst = next_rst;
    WB_ExceptType = ex; WB_PC = pc; WB_ALUOut = alu; WB_IsDelaySlot = ds;
    WB_CP0Wr = wr; WB_CP0Addr = wa; WB_OutB = wd; CP0_RdAddr = ra; HWInt = cur_hw;
    #1;
    e_flush = !rst && (ex != 0);
    chk("flush", 32'(CP0_Flush), 32'(e_flush));
    if (e_flush) chk("npc", CP0_NPC, ((ex & 9'h1FB) != 0) ? ENTRY : m_epc);
    chk("rddata", CP0_RdData, m_read(ra));
    chk("intpend", 32'(CP0_IntPending), 32'(m_intpend()));
    chk("status", CP0_Status, m_status);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input logic [4:0] ra);
    set_in(9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, ra);
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
    set_in(9'h0, 32'h0, 32'h0, 1'b0, 1'b1, wa, wd, 5'd0);
    tick();
  endtask

  task automatic exc(input logic [8:0] ex, input logic [31:0] pc, input logic [31:0] alu,
                     input logic ds);
    set_in(ex, pc, alu, ds, 1'b0, 5'd0, 32'h0, 5'd0);
    tick();
  endtask

  initial begin
    logic [4:0] addrs[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    logic [8:0] ex;
    int r;

    // reset; the reset cycle must not flush even with an exception present
    next_rst = 1'b1;
    repeat (2) @(posedge clk);
    model_step();
    set_in(9'h010, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12);
    chk("rst_flush", 32'(CP0_Flush), 32'h0);
    tick();
    next_rst = 1'b0;

    idle(5'd12); chk("rst_status", CP0_RdData, 32'h0040_0000); tick();
    idle(5'd14); chk("rst_epc", CP0_RdData, 32'h0); tick();
    idle(5'd9);  chk("count_1", CP0_RdData, 32'h1); tick();
    idle(5'd13); chk("rst_cause", CP0_RdData, 32'h0); tick();
    idle(5'd9);  chk("count_2", CP0_RdData, 32'h2); tick();

    set_in(9'h010, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
    chk("sys_flush", 32'(CP0_Flush), 32'h1);
    chk("sys_npc", CP0_NPC, 32'hBFC0_0380);
    tick();
    idle(5'd14); chk("sys_epc", CP0_RdData, 32'h8000_0100); tick();
    idle(5'd13); chk("sys_cause", CP0_RdData, 32'h0000_0020); tick();
    idle(5'd12); chk("sys_exl", CP0_RdData, 32'h0040_0002); tick();

    set_in(9'h004, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
    chk("eret_npc", CP0_NPC, 32'h8000_0100);
    tick();
    idle(5'd12); chk("eret_exl", CP0_RdData, 32'h0040_0000); tick();

    exc(9'h020, 32'h8000_0204, 32'h0, 1'b1);
    idle(5'd14); chk("ov_ds_epc", CP0_RdData, 32'h8000_0200); tick();
    idle(5'd13); chk("ov_ds_cause", CP0_RdData, 32'h8000_0030); tick();
    exc(9'h020, 32'h8000_0300, 32'h0, 1'b0);
    idle(5'd14); chk("nested_epc", CP0_RdData, 32'h8000_0200); tick();
    idle(5'd13); chk("nested_cause", CP0_RdData, 32'h8000_0030); tick();

    exc(9'h003, 32'h8000_0500, 32'h1000_0002, 1'b0);
    idle(5'd8);  chk("mem_badva", CP0_RdData, 32'h1000_0002); tick();
    idle(5'd13); chk("mem_code", CP0_RdData, 32'h8000_0010); tick();
    exc(9'h0A0, 32'h8000_0400, 32'h1234_5678, 1'b0);
    idle(5'd8);  chk("if_badva", CP0_RdData, 32'h8000_0400); tick();
    idle(5'd13); chk("if_code", CP0_RdData, 32'h8000_0010); tick();

    set_in(9'h010, 32'h8000_0600, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_FF01, 5'd0);
    tick();
    idle(5'd12); chk("mtc0_drop", CP0_RdData, 32'h0040_0002); tick();
    exc(9'h004, 32'h0, 32'h0, 1'b0);

    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 12; i++) begin idle(5'd13); tick(); end
    idle(5'd13);
    chk("timer_ti", CP0_RdData & 32'h4000_8000, 32'h4000_8000);
    chk("timer_int", 32'(CP0_IntPending), 32'h1);
    tick();
    mtc0(5'd11, 32'd100);
    idle(5'd13);
    chk("ti_clear", CP0_RdData & 32'h4000_0000, 32'h0);
    chk("ti_int_clear", 32'(CP0_IntPending), 32'h0);
    tick();
    cur_hw = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    idle(5'd13); chk("hw_int", 32'(CP0_IntPending), 32'h1); tick();
    cur_hw = '0;

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ex = 9'($urandom);
      else if (r < 3) ex = 9'(1 << $urandom_range(0, 8));
      else ex = 9'h0;
      cur_hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      next_rst = ($urandom_range(0, 99) == 0);
      set_in(ex, $urandom, $urandom, 1'($urandom), ($urandom_range(0, 2) == 0),
             addrs[$urandom_range(0, 6)],
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom,
             addrs[$urandom_range(0, 6)]);
      tick();
    end
    next_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
